warp_scheduler: RTL and testbench

- Per-core warp scheduler that succeeds the fixed two-warp, converged-PC scheduler.
- Parametrised in warp count, threads per warp and PC width.
- Tracks a PC per thread and a done flag per thread, so branch divergence is handled by min-PC serialisation with implicit reconvergence.
- Sequences the core pipeline states and picks the next live warp round-robin, skipping finished warps. Sits between the fetcher, decoder, LSUs and per-thread PC units inside each core.

---
 rtl/gpu_pkg.sv | 17 +
 rtl/warp_issue_select.sv | 24 ++
 rtl/warp_scheduler.sv | 125 ++++++++++++
 tb/tb_warp_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared core pipeline encodings and width helper
package gpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110
  } core_state_t;
  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_WAITING = 2'b01;
  function automatic int clog2_safe(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/warp_issue_select.sv
// warp_issue_select: picks the minimum live PC of one warp and the threads sitting at it
module warp_issue_select
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS = 8
) (
  input  logic [PC_BITS*THREADS_PER_WARP-1:0] pcs,
  input  logic [THREADS_PER_WARP-1:0]         live,
  output logic [PC_BITS-1:0]                  current_pc,
  output logic [THREADS_PER_WARP-1:0]         thread_enable
);
  logic [PC_BITS-1:0] min_pc;
  // lowest PC among live threads issues first; threads sharing it run together
  always_comb begin
    min_pc = '1;
    thread_enable = '0;
    for (int i = 0; i < THREADS_PER_WARP; i++)
      if (live[i] && pcs[i*PC_BITS +: PC_BITS] < min_pc) min_pc = pcs[i*PC_BITS +: PC_BITS];
    current_pc = |live ? min_pc : '0;
    for (int i = 0; i < THREADS_PER_WARP; i++)
      thread_enable[i] = live[i] && pcs[i*PC_BITS +: PC_BITS] == current_pc;
  end
endmodule

// File: rtl/warp_scheduler.sv
// warp_scheduler: per-thread-PC warp scheduler sequencing the core pipeline round-robin
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter int MAX_WARPS = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS = 8,
  parameter int TC_BITS = 8,
  localparam int WARP_ID_BITS = clog2_safe(MAX_WARPS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [TC_BITS-1:0]                  thread_count,
  input  logic [2:0]                          fetcher_state,
  input  logic                                decoded_ret,
  input  logic [2*THREADS_PER_WARP-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_WARP-1:0] next_pc,
  output logic [2:0]                          core_state,
  output logic [WARP_ID_BITS-1:0]             current_warp_id,
  output logic [PC_BITS-1:0]                  current_pc,
  output logic [THREADS_PER_WARP-1:0]         thread_enable,
  output logic                                done
);
  core_state_t state_q, state_d;
  logic [WARP_ID_BITS-1:0] warp_q, warp_d, nxt, cand;
  logic done_q, done_d, found;
  logic [TC_BITS-1:0] tc_q, tc_d;
  logic [PC_BITS-1:0] pc_q [MAX_WARPS][THREADS_PER_WARP];
  logic [PC_BITS-1:0] pc_d [MAX_WARPS][THREADS_PER_WARP];
  logic [THREADS_PER_WARP-1:0] tdone_q [MAX_WARPS];
  logic [THREADS_PER_WARP-1:0] tdone_d [MAX_WARPS];
  logic [THREADS_PER_WARP-1:0] valid [MAX_WARPS];
  logic [PC_BITS*THREADS_PER_WARP-1:0] cur_pcs;
  logic [THREADS_PER_WARP-1:0] cur_live, lsu_wait;
  // a thread slot exists only if its global index is below the latched count
  always_comb
    for (int w = 0; w < MAX_WARPS; w++)
      for (int i = 0; i < THREADS_PER_WARP; i++)
        valid[w][i] = (w*THREADS_PER_WARP + i) < int'(tc_q);
  // slice out the current warp for issue selection and LSU stall detection
  always_comb begin
    cur_pcs = '0;
    for (int i = 0; i < THREADS_PER_WARP; i++) begin
      cur_pcs[i*PC_BITS +: PC_BITS] = pc_q[warp_q][i];
      lsu_wait[i] = lsu_state[2*i +: 2] == LSU_WAITING;
    end
    cur_live = valid[warp_q] & ~tdone_q[warp_q];
  end
  warp_issue_select #(
    .THREADS_PER_WARP(THREADS_PER_WARP),
    .PC_BITS(PC_BITS)
  ) u_sel (
    .pcs(cur_pcs),
    .live(cur_live),
    .current_pc(current_pc),
    .thread_enable(thread_enable)
  );
  // pipeline sequencing, per-thread retirement and round-robin warp choice
  always_comb begin
    state_d = state_q;
    warp_d = warp_q;
    done_d = done_q;
    tc_d = tc_q;
    pc_d = pc_q;
    tdone_d = tdone_q;
    found = 1'b0;
    nxt = warp_q;
    cand = warp_q;
    case (state_q)
      S_IDLE: if (start && !done_q) begin
        tc_d = thread_count;
        done_d = thread_count == '0;
        state_d = thread_count == '0 ? S_IDLE : S_FETCH;
        warp_d = '0;
      end
      S_FETCH:   state_d = fetcher_state == FETCHER_FETCHED ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    state_d = |(thread_enable & lsu_wait) ? S_WAIT : S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        for (int i = 0; i < THREADS_PER_WARP; i++)
          if (thread_enable[i]) begin
            if (decoded_ret) tdone_d[warp_q][i] = 1'b1;
            else pc_d[warp_q][i] = next_pc[i*PC_BITS +: PC_BITS];
          end
        for (int k = 1; k <= MAX_WARPS; k++) begin
          cand = WARP_ID_BITS'((int'(warp_q) + k) % MAX_WARPS);
          if (!found && |(valid[cand] & ~tdone_d[cand])) begin
            found = 1'b1;
            nxt = cand;
          end
        end
        state_d = found ? S_FETCH : S_IDLE;
        done_d = !found;
        warp_d = nxt;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; reset aborts any running kernel
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      warp_q <= '0;
      done_q <= 1'b0;
      tc_q <= '0;
      for (int w = 0; w < MAX_WARPS; w++) begin
        tdone_q[w] <= '0;
        for (int i = 0; i < THREADS_PER_WARP; i++) pc_q[w][i] <= '0;
      end
    end else begin
      state_q <= state_d;
      warp_q <= warp_d;
      done_q <= done_d;
      tc_q <= tc_d;
      pc_q <= pc_d;
      tdone_q <= tdone_d;
    end
  end
  assign core_state = state_q;
  assign current_warp_id = warp_q;
  assign done = done_q;
endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: directed scoreboard bench for warp_scheduler
module tb_warp_scheduler;
  import gpu_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, decoded_ret = 1'b0;
  logic [7:0] thread_count = '0;
  logic [2:0] fetcher_state = 3'b010;
  logic [7:0] lsu_state = '0;
  logic [31:0] next_pc = '0;
  logic [2:0] core_state;
  logic [1:0] current_warp_id;
  logic [7:0] current_pc;
  logic [3:0] thread_enable;
  logic done;
  int checks = 0, errors = 0;
  typedef struct {int warp; int pc; int en;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  warp_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .fetcher_state(fetcher_state), .decoded_ret(decoded_ret), .lsu_state(lsu_state),
    .next_pc(next_pc), .core_state(core_state), .current_warp_id(current_warp_id),
    .current_pc(current_pc), .thread_enable(thread_enable), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (core_state == s) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout waiting for state %0d (at %0d)", s, core_state);
  endtask

  task automatic launch(input int n);
    start = 1'b1;
    thread_count = 8'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input int w, input int pc, input int en, input logic ret, input logic [31:0] npc);
    q.push_back(exp_t'{w, pc, en});
    decoded_ret = ret;
    next_pc = npc;
    wait_state(S_UPDATE);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string name, input int exp_done);
    chk({name, "_state"}, core_state, S_IDLE);
    chk({name, "_done"}, done, exp_done);
  endtask

  always @(negedge clk)
    if (!reset && core_state == S_UPDATE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected issue: warp %0d pc %0d en %b", current_warp_id, current_pc, thread_enable);
      end else begin
        e = q.pop_front();
        chk("issue_warp", current_warp_id, e.warp);
        chk("issue_pc", current_pc, e.pc);
        chk("issue_en", thread_enable, e.en);
      end
    end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset", 0);
    chk("reset_warp", current_warp_id, 0);
    chk("reset_pc", current_pc, 0);
    chk("reset_en", thread_enable, 0);

    launch(10);
    chk("start_fetch", core_state, S_FETCH);
    issue(0, 0, 4'b1111, 1'b0, {8'd5, 8'd5, 8'd9, 8'd9});
    issue(1, 0, 4'b1111, 1'b0, {4{8'd1}});
    issue(2, 0, 4'b0011, 1'b0, {4{8'd1}});
    issue(0, 5, 4'b1100, 1'b0, {4{8'd9}});
    issue(1, 1, 4'b1111, 1'b0, {4{8'hFF}});
    issue(2, 1, 4'b0011, 1'b1, '0);
    issue(0, 9, 4'b1111, 1'b1, '0);
    issue(1, 255, 4'b1111, 1'b1, '0);
    chk_idle("tc10_end", 1);
    launch(4);
    repeat (3) @(negedge clk);
    chk_idle("restart_ignored", 1);

    do_reset();
    chk_idle("reset2", 0);
    launch(3);
    q.push_back(exp_t'{0, 0, 4'b0111});
    decoded_ret = 1'b0;
    next_pc = {4{8'd7}};
    lsu_state = 8'b01_00_01_00;
    wait_state(S_WAIT);
    repeat (5) begin
      @(negedge clk);
      chk("wait_hold", core_state, S_WAIT);
    end
    lsu_state = 8'b01_00_00_00;
    wait_state(S_UPDATE);
    @(negedge clk);
    lsu_state = '0;
    issue(0, 7, 4'b0111, 1'b1, '0);
    chk_idle("tc3_end", 1);
    launch(5);
    repeat (3) @(negedge clk);
    chk_idle("tc3_restart_ignored", 1);

    do_reset();
    launch(0);
    chk_idle("tc0", 1);
    repeat (3) begin
      @(negedge clk);
      chk("tc0_no_fetch", core_state, S_IDLE);
    end

    do_reset();
    launch(10);
    issue(0, 0, 4'b1111, 1'b0, {4{8'd3}});
    wait_state(S_EXECUTE);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("abort", 0);
    chk("abort_warp", current_warp_id, 0);
    chk("abort_pc", current_pc, 0);
    launch(10);
    issue(0, 0, 4'b1111, 1'b0, {4{8'd2}});
    issue(1, 0, 4'b1111, 1'b0, {4{8'd2}});

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
